// File: rtl/pc_fetch_sequencer.sv
// ============================================================================
// pc_fetch_sequencer
// ----------------------------------------------------------------------------
// This block owns the program counter and sequences instruction fetches for
// the MIPS core. It issues req/ack fetches to instruction memory and picks the
// next PC from several sources: sequential (pc+4), branch, jump, and an
// optional exception vector. It honours stalls and hands each fetched word to
// decode together with its PC.
//
// Optional feature macro: PCSEQ_EXC_EN
//   When this macro is defined, the block gains an `exc` input and an `epc`
//   output. An exception redirect has priority over jump and branch.
//
// Parameters
//   RESET_PC    PC value loaded on reset.
//   TIMEOUT     Maximum number of FETCH cycles without imem_ack before
//               fetch_err is raised. A value of 0 disables the timeout.
//   EXC_VECTOR  Exception target address (used only with PCSEQ_EXC_EN).
//
// Ports
//   clk          in   1   clock, rising edge
//   rst          in   1   asynchronous active-low reset
//   run          in   1   enable fetching; 0 parks in IDLE after current fetch
//   stall        in   1   no new fetch issued while high
//   br_taken     in   1   branch redirect pulse
//   br_offset    in   32  signed byte offset (already shifted by 2)
//   jump         in   1   jump redirect pulse
//   jump_target  in   32  absolute jump byte address
//   imem_req     out  1   fetch request
//   imem_addr    out  32  fetch address (equals pc)
//   imem_ack     in   1   fetch complete; imem_rdata valid this cycle
//   imem_rdata   in   32  fetched instruction word
//   instr_valid  out  1   one-cycle pulse: instr/instr_pc valid
//   instr        out  32  delivered instruction
//   instr_pc     out  32  PC of delivered instruction
//   pc           out  32  current PC register
//   fetch_err    out  1   sticky timeout flag, cleared only by reset
//   exc          in   1   exception pulse            (PCSEQ_EXC_EN only)
//   epc          out  32  instr_pc at exception time (PCSEQ_EXC_EN only)
// ============================================================================
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned TIMEOUT    = 16,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_offset,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc,
  output logic        fetch_err
`ifdef PCSEQ_EXC_EN
  ,
  input  logic        exc,
  output logic [31:0] epc
`endif
);

  // The counter only has to reach TIMEOUT-1: the cycle that would have been
  // cycle number TIMEOUT is the one that raises the error.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               tmo_hit;
  logic [CNT_W-1:0]   tmo_cnt;
  logic               pend_vld;
  logic [31:0]        pend_tgt;

  logic               redir;
  logic [31:0]        redir_raw;
  logic [31:0]        redir_tgt;
  logic signed [31:0] br_off_s;
  logic signed [31:0] br_sum;

  // Branches are relative to the most recently delivered instruction.
  assign br_off_s = br_offset;
  assign br_sum   = signed'(instr_pc) + 32'sd4 + br_off_s;

`ifdef PCSEQ_EXC_EN
  assign redir = exc | jump | br_taken;

  always_comb begin
    if (exc)       redir_raw = EXC_VECTOR;
    else if (jump) redir_raw = jump_target;
    else           redir_raw = unsigned'(br_sum);
  end
`else
  logic unused_exc_vector;
  assign unused_exc_vector = ^EXC_VECTOR;

  assign redir = jump | br_taken;

  always_comb begin
    if (jump) redir_raw = jump_target;
    else      redir_raw = unsigned'(br_sum);
  end
`endif

  // Instruction addresses are word aligned; the low address bits are dropped.
  assign redir_tgt = redir_raw & 32'hFFFF_FFFC;

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;

  // ---- FSM state register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // ---- FSM next-state ----
  // While a request is outstanding, stall is ignored. It is only consulted
  // at the moment the ack arrives.
  always_comb begin
    state_nxt = state;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (run && !fetch_err) state_nxt = stall ? HOLD : FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          if (!run)       state_nxt = IDLE;
          else if (stall) state_nxt = HOLD;
          else            state_nxt = FETCH;
        end else if ((TIMEOUT != 0) && (tmo_cnt == TMO_LAST)) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (!stall) state_nxt = run ? FETCH : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- PC, pending redirect, timeout and delivery registers ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= 32'h0;
      instr_pc    <= 32'h0;
      fetch_err   <= 1'b0;
      pend_vld    <= 1'b0;
      pend_tgt    <= 32'h0;
      tmo_cnt     <= '0;
    end else begin
      instr_valid <= 1'b0;
      case (state)
        FETCH: begin
          if (imem_ack) begin
            tmo_cnt  <= '0;
            pend_vld <= 1'b0;
            // A redirect in the same cycle as the ack, or one still pending,
            // makes the returned word stale, so it is dropped.
            if (redir) begin
              pc <= redir_tgt;
            end else if (pend_vld) begin
              pc <= pend_tgt;
            end else begin
              instr_valid <= 1'b1;
              instr       <= imem_rdata;
              instr_pc    <= pc;
              pc          <= pc + 32'd4;
            end
          end else if (tmo_hit) begin
            // Abandon the fetch and keep pc so the faulting address stays visible.
            fetch_err <= 1'b1;
            tmo_cnt   <= '0;
            pend_vld  <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            // The address must not change under an outstanding request, so
            // the redirect is held until the ack. A newer redirect wins.
            if (redir) begin
              pend_vld <= 1'b1;
              pend_tgt <= redir_tgt;
            end
          end
        end
        default: begin
          tmo_cnt <= '0;
          if (redir) pc <= redir_tgt;
        end
      endcase
    end
  end

`ifdef PCSEQ_EXC_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     epc <= 32'h0;
    else if (exc) epc <= instr_pc;
  end
`endif

endmodule
